// File: rtl/addr_fifo_if.sv
// Bus bundle for addr_fifo: push-source select, push/pop/flush controls and FIFO status.
// The same WIDTH/DEPTH must be given to the interface and to the addr_fifo instance.
interface addr_fifo_if #(
    parameter int unsigned WIDTH = 11,
    parameter int unsigned DEPTH = 4
);
    logic                     enable;
    logic                     select;
    logic                     push;
    logic                     pop;
    logic                     flush;
    logic [WIDTH-1:0]         i1;
    logic [WIDTH-1:0]         i2;
    logic [WIDTH-1:0]         p;
    logic [$clog2(DEPTH):0]   count;
    logic                     full;
    logic                     empty;
    logic                     overflow;
    logic                     underflow;

    modport master (
        output enable, select, push, pop, flush, i1, i2,
        input  p, count, full, empty, overflow, underflow
    );

    modport slave (
        input  enable, select, push, pop, flush, i1, i2,
        output p, count, full, empty, overflow, underflow
    );
endinterface

// File: rtl/addr_fifo.sv
// Show-ahead address FIFO choosing PC (i1) or instruction field (i2) as the push source.
// Sticky overflow/underflow flags exist only when ADDR_FIFO_ERR_FLAGS_EN is defined.
module addr_fifo #(
    parameter int unsigned WIDTH = 11,
    parameter int unsigned DEPTH = 4
) (
    input logic         clk,
    input logic         reset_n,
    addr_fifo_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic             w_full;
    logic             w_empty;
    logic [WIDTH-1:0] w_src;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_src   = (bus.enable && !bus.select) ? bus.i2 : bus.i1;

    // A full FIFO still accepts a push when a pop frees the head slot in the same cycle.
    assign w_do_pop  = bus.pop && !w_empty;
    assign w_do_push = bus.push && (!w_full || bus.pop);

    always_ff @(posedge clk) begin
        if (w_do_push && !bus.flush) begin
            r_mem[r_wr_ptr] <= w_src;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (bus.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    assign bus.p     = w_empty ? '0 : r_mem[r_rd_ptr];
    assign bus.count = r_count;
    assign bus.full  = w_full;
    assign bus.empty = w_empty;

`ifdef ADDR_FIFO_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (bus.flush) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (bus.push && w_full && !bus.pop) begin
                r_overflow <= 1'b1;
            end
            if (bus.pop && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;
`else
    assign bus.overflow  = 1'b0;
    assign bus.underflow = 1'b0;
`endif
endmodule

// File: tb/tb_addr_fifo.sv
// Self-checking bench for addr_fifo: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_addr_fifo;
    localparam int unsigned WIDTH = 11;
    localparam int unsigned DEPTH = 4;
`ifdef ADDR_FIFO_ERR_FLAGS_EN
    localparam bit FLAGS_EN = 1'b1;
`else
    localparam bit FLAGS_EN = 1'b0;
`endif

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_errors;
    bit   cmp_en;

    addr_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    addr_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of entries plus two sticky bits.
    logic [WIDTH-1:0] m_q[$];
    bit               m_ovf;
    bit               m_unf;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (bus.flush) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            automatic int unsigned sz = m_q.size();
            automatic bit popped = bus.pop && (sz > 0);
            automatic bit pushed = bus.push && ((sz < DEPTH) || popped);
            automatic logic [WIDTH-1:0] src = (bus.enable && !bus.select) ? bus.i2 : bus.i1;
            if (popped) void'(m_q.pop_front());
            if (pushed) m_q.push_back(src);
            if (bus.push && !pushed) m_ovf = 1'b1;
            if (bus.pop && sz == 0) m_unf = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            automatic int unsigned sz = m_q.size();
            automatic logic [WIDTH-1:0] exp_p = (sz > 0) ? m_q[0] : '0;
            check("p", 32'(bus.p), 32'(exp_p));
            check("count", 32'(bus.count), sz);
            check("full", 32'(bus.full), 32'(sz == DEPTH));
            check("empty", 32'(bus.empty), 32'(sz == 0));
            check("overflow", 32'(bus.overflow), 32'(FLAGS_EN & m_ovf));
            check("underflow", 32'(bus.underflow), 32'(FLAGS_EN & m_unf));
        end
    end

    // Inputs are applied 2 time units after a rising edge and held for one full cycle.
    task automatic op(input bit ps, input bit pp, input bit fl, input bit en, input bit sel,
                      input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        bus.push = ps; bus.pop = pp; bus.flush = fl;
        bus.enable = en; bus.select = sel; bus.i1 = a; bus.i2 = b;
        @(posedge clk);
        #2;
        bus.push = 1'b0; bus.pop = 1'b0; bus.flush = 1'b0;
        bus.enable = 1'b0; bus.select = 1'b0; bus.i1 = '0; bus.i2 = '0;
    endtask

    task automatic push1(input logic [WIDTH-1:0] v);
        op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, v, '0);
    endtask

    task automatic do_flush();
        op(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
    endtask

    logic [WIDTH-1:0] seq[$];

    initial begin
        n_checks = 0; n_errors = 0; cmp_en = 1'b0;
        reset_n = 1'b0;
        bus.push = 1'b0; bus.pop = 1'b0; bus.flush = 1'b0;
        bus.enable = 1'b0; bus.select = 1'b0; bus.i1 = '0; bus.i2 = '0;
        @(posedge clk);
        #1;
        check("reset_count", 32'(bus.count), 0);
        check("reset_empty", 32'(bus.empty), 1);
        check("reset_p", 32'(bus.p), 0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        cmp_en = 1'b1;
        @(posedge clk);
        #2;

        // Scenario 1: source mux and show-ahead head
        op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'h123, 11'h5AA);
        check("s1_p_after_first_push", 32'(bus.p), 32'h123);
        op(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 11'h3C3, 11'h456);
        check("s1_p", 32'(bus.p), 32'h123);
        check("s1_count", 32'(bus.count), 2);
        op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        check("s1_p_after_pop", 32'(bus.p), 32'h456);
        op(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 11'h0F0, 11'h00F);
        op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        check("s1_sel1_takes_i1", 32'(bus.p), 32'h0F0);
        do_flush();

        // Scenario 2: overfill then drain
        for (int i = 1; i <= 5; i++) push1(WIDTH'(i));
        check("s2_full", 32'(bus.full), 1);
        check("s2_overflow", 32'(bus.overflow), 32'(FLAGS_EN));
        for (int i = 1; i <= 4; i++) begin
            check("s2_drain", 32'(bus.p), i);
            op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        end
        check("s2_empty", 32'(bus.empty), 1);
        check("s2_p_zero", 32'(bus.p), 0);
        do_flush();
        check("flush_clears_ovf", 32'(bus.overflow), 0);

        // Scenario 3: push+pop while full
        for (int i = 1; i <= 4; i++) push1(WIDTH'(i + 32'h10));
        op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'h7FF, '0);
        check("s3_count", 32'(bus.count), 4);
        check("s3_overflow", 32'(bus.overflow), 0);
        for (int i = 2; i <= 4; i++) op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        check("s3_last", 32'(bus.p), 32'h7FF);
        check("s3_last_count", 32'(bus.count), 1);
        do_flush();

        // Scenario 4: push+pop while empty
        op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'h0AA, '0);
        check("s4_count", 32'(bus.count), 1);
        check("s4_p", 32'(bus.p), 32'h0AA);
        check("s4_underflow", 32'(bus.underflow), 32'(FLAGS_EN));
        do_flush();

        // Scenario 5: ten push/pop pairs across pointer wrap, then flush with push
        seq.delete();
        push1(11'h201); seq.push_back(11'h201);
        push1(11'h202); seq.push_back(11'h202);
        push1(11'h203); seq.push_back(11'h203);
        for (int i = 0; i < 10; i++) begin
            automatic logic [WIDTH-1:0] v = WIDTH'(32'h300 + i);
            check("s5_order", 32'(bus.p), 32'(seq.pop_front()));
            op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, v, '0);
            seq.push_back(v);
            check("s5_count", 32'(bus.count), 3);
        end
        op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'h111, '0);
        op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'h112, '0);
        op(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 11'h555, '0);
        check("s5_flush_count", 32'(bus.count), 0);
        check("s5_flush_ovf", 32'(bus.overflow), 0);
        check("s5_flush_unf", 32'(bus.underflow), 0);
        check("s5_flush_p", 32'(bus.p), 0);

        // Scenario 6: asynchronous reset with three entries held
        op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        push1(11'h061); push1(11'h062); push1(11'h063);
        check("s6_count_before", 32'(bus.count), 3);
        check("s6_underflow_before", 32'(bus.underflow), 32'(FLAGS_EN));
        bus.push = 1'b1; bus.i1 = 11'h0EE;
        reset_n = 1'b0;
        #1;
        check("s6_async_count", 32'(bus.count), 0);
        check("s6_async_empty", 32'(bus.empty), 1);
        check("s6_async_full", 32'(bus.full), 0);
        check("s6_async_p", 32'(bus.p), 0);
        check("s6_async_unf", 32'(bus.underflow), 0);
        bus.push = 1'b0; bus.i1 = '0;
        @(negedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #2;
        check("s6_no_partial_write", 32'(bus.count), 0);
        push1(11'h1B7);
        check("s6_first_op", 32'(bus.p), 32'h1B7);
        check("s6_first_count", 32'(bus.count), 1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            op(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 50),
               ($urandom_range(0, 39) == 0), 1'($urandom), 1'($urandom),
               WIDTH'($urandom), WIDTH'($urandom));
        end

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/addr_fifo.md
ADDR_FIFO -- requirements
Module: addr_fifo

Interface
REQ-001 Parameter WIDTH, default 11, SHALL set the data width of inputs i1, i2 and output p.
REQ-002 Parameter DEPTH, default 4, power of two, >= 2, SHALL set the number of storage entries.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 enable  input  1  SHALL gate the source select; when low, the push source SHALL be i1.
REQ-006 select  input  1  SHALL choose the push source when enable=1: 1 selects i1 (PC), 0 selects i2 (instruction field).
REQ-007 push  input  1  SHALL request a write of the selected source.
REQ-008 pop  input  1  SHALL request removal of the head entry.
REQ-009 flush  input  1  SHALL be a synchronous clear of contents and flags.
REQ-010 i1, i2  input  WIDTH  SHALL be the two candidate push sources.
REQ-011 p  output  WIDTH  SHALL present the head (oldest) entry; all zero when empty.
REQ-012 count  output  $clog2(DEPTH)+1  SHALL be the number of valid entries.
REQ-013 full, empty  output  1  SHALL be high when count equals DEPTH, or 0, respectively.
REQ-014 overflow, underflow  output  1  SHALL be the sticky error flags.

Function
REQ-015 Source mux: the push source SHALL be i2 only when enable=1 and select=0; otherwise i1.
REQ-016 Push when not full: the selected source SHALL be written at the tail; count +1 at the next edge.
REQ-017 Pop when not empty: the head SHALL advance; count -1 at the next edge.
REQ-018 p SHALL be show-ahead: the head value SHALL be visible combinationally from registered storage, with zero-cycle pop latency and a one-cycle push-to-p latency when empty.
REQ-019 Read and write pointers SHALL wrap modulo DEPTH with no bubble.
REQ-020 Push and pop together with 0 < count < DEPTH: both SHALL be performed, and count SHALL be unchanged.
REQ-021 Push and pop together when full: both SHALL be performed, count SHALL stay DEPTH, and overflow SHALL NOT be set.
REQ-022 Push and pop together when empty: the push SHALL be performed, the pop ignored, and underflow SHALL be set.
REQ-023 Push when full without pop: the write SHALL be dropped, contents unchanged, and overflow SHALL be set.
REQ-024 Pop when empty without push: it SHALL be ignored, and underflow SHALL be set.
REQ-025 Overflow and underflow SHALL remain set until flush or reset.
REQ-026 flush=1 SHALL take priority over push and pop in the same cycle: pointers, count, overflow and underflow SHALL be set to 0 at the edge.
REQ-027 Storage contents SHALL NOT be required to clear on flush; p SHALL read zero because the FIFO is empty.

Reset
REQ-028 When reset_n=0, the block SHALL immediately, without a clock, set pointers=0, count=0, empty=1, full=0, overflow=0, underflow=0 and p=0.
REQ-029 Reset asserted during a push or pop SHALL abort the operation; no partial write SHALL be visible after release.
REQ-030 The first operation after reset_n rises SHALL be accepted at the first rising clk edge.

Configuration
REQ-031 Macro ADDR_FIFO_ERR_FLAGS_EN defined: overflow and underflow SHALL behave per REQ-022 to REQ-026.
REQ-032 Macro ADDR_FIFO_ERR_FLAGS_EN undefined: overflow and underflow SHALL be tied 0, no flag registers SHALL be synthesised, and all drop/ignore behaviour SHALL be unchanged.

Verification
REQ-033 Scenario 1: reset, then push i1=0x123 (enable=0), then push i2=0x456 (enable=1, select=0) -> p=0x123, count=2; after pop, p=0x456.
REQ-034 Scenario 2: DEPTH=4, five pushes of 1..5 -> full=1, overflow=1; drain gives 1,2,3,4, then empty=1 and p=0.
REQ-035 Scenario 3: full FIFO, push 0x7FF with pop in the same cycle -> count stays 4, overflow=0, and 0x7FF is output last.
REQ-036 Scenario 4: empty FIFO, push 0x0AA with pop in the same cycle -> count=1, p=0x0AA, underflow=1.
REQ-037 Scenario 5: 10 push/pop pairs on DEPTH=4 -> pointer wrap is exercised and order is preserved; then flush together with push -> count=0 and flags=0.
REQ-038 Scenario 6: reset_n pulsed low between clock edges with count=3 -> outputs reach reset values before the next edge; rerun with the macro undefined -> flags stay 0.
